// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - 16-bit ALU request/response sequencer with iterative multiply and shifts
module alu_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_req_valid,
   output logic             o_req_ready,
   input  logic [4:0]       i_opcode,
   input  logic [WIDTH-1:0] i_operand_a,
   input  logic [WIDTH-1:0] i_operand_b,
   output logic             o_resp_valid,
   input  logic             i_resp_ready,
   output logic [WIDTH-1:0] o_result,
   output logic             o_carry,
   output logic             o_overflow,
   output logic             o_zero,
   output logic             o_error,
   output logic             o_busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_ITER = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [4:0] OP_ADD = 5'd0;
   localparam logic [4:0] OP_SUB = 5'd1;
   localparam logic [4:0] OP_AND = 5'd2;
   localparam logic [4:0] OP_OR  = 5'd3;
   localparam logic [4:0] OP_XOR = 5'd4;
   localparam logic [4:0] OP_NOT = 5'd5;
   localparam logic [4:0] OP_EQ  = 5'd6;
   localparam logic [4:0] OP_MUL = 5'd7;
   localparam logic [4:0] OP_SHL = 5'd8;
   localparam logic [4:0] OP_SHR = 5'd9;

   logic [1:0]         r_state;
   logic [4:0]         r_op;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [3:0]         r_cnt;
   logic [WIDTH-1:0]   r_result;
   logic               r_carry;
   logic               r_overflow;
   logic               r_zero;
   logic               r_error;

   logic [WIDTH:0]     w_ext;
   logic [WIDTH-1:0]   w_res;
   logic               w_c;
   logic               w_v;
   logic               w_e;
   logic [2*WIDTH-1:0] w_acc_next;
   logic [WIDTH-1:0]   w_sh_next;
   logic               w_sh_out;
   logic               w_iterative;

   // Single-pass result and flags from the latched operands (EXEC state)
   always_comb begin
      w_ext = '0;
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      w_e   = 1'b0;
      case (r_op)
         OP_ADD: begin
            w_ext = {1'b0, r_a} + {1'b0, r_b};
            w_res = w_ext[WIDTH-1:0];
            w_c   = w_ext[WIDTH];
            w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
         end
         OP_SUB: begin
            w_ext = {1'b0, r_a} - {1'b0, r_b};
            w_res = w_ext[WIDTH-1:0];
            w_c   = w_ext[WIDTH];
            w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
         end
         OP_AND:  w_res = r_a & r_b;
         OP_OR:   w_res = r_a | r_b;
         OP_XOR:  w_res = r_a ^ r_b;
         OP_NOT:  w_res = ~r_a;
         OP_EQ:   w_res = (r_a == r_b) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
         OP_SHL,
         OP_SHR:  w_res = r_a;   // only shift-by-0 reaches EXEC
         default: w_e   = 1'b1;
      endcase
   end

   // One multiply step and one single-bit shift step (ITER state)
   always_comb begin
      w_acc_next = r_b[0] ? (r_acc + r_mcand) : r_acc;
      if (r_op == OP_SHL) begin
         w_sh_next = {r_a[WIDTH-2:0], 1'b0};
         w_sh_out  = r_a[WIDTH-1];
      end else begin
         w_sh_next = {1'b0, r_a[WIDTH-1:1]};
         w_sh_out  = r_a[0];
      end
   end

   assign w_iterative = (i_opcode == OP_MUL) ||
                        (((i_opcode == OP_SHL) || (i_opcode == OP_SHR)) && (i_operand_b[3:0] != 4'd0));

   // Sequencer state, operand latches, iteration datapath and registered response
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_op       <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_acc      <= '0;
         r_mcand    <= '0;
         r_cnt      <= '0;
         r_result   <= '0;
         r_carry    <= 1'b0;
         r_overflow <= 1'b0;
         r_zero     <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_req_valid) begin
                  r_op    <= i_opcode;
                  r_a     <= i_operand_a;
                  r_b     <= i_operand_b;
                  r_acc   <= '0;
                  r_mcand <= {{WIDTH{1'b0}}, i_operand_a};
                  r_cnt   <= (i_opcode == OP_MUL) ? 4'd15 : (i_operand_b[3:0] - 4'd1);
                  r_state <= w_iterative ? S_ITER : S_EXEC;
               end
            end
            S_EXEC: begin
               r_result   <= w_res;
               r_carry    <= w_c;
               r_overflow <= w_v;
               r_zero     <= (w_res == '0);
               r_error    <= w_e;
               r_state    <= S_DONE;
            end
            S_ITER: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_op == OP_MUL) begin
                  r_acc   <= w_acc_next;
                  r_mcand <= {r_mcand[2*WIDTH-2:0], 1'b0};
                  r_b     <= {1'b0, r_b[WIDTH-1:1]};
               end else begin
                  r_a <= w_sh_next;
               end
               if (r_cnt == 4'd0) begin
                  r_overflow <= 1'b0;
                  r_error    <= 1'b0;
                  r_state    <= S_DONE;
                  if (r_op == OP_MUL) begin
                     r_result <= w_acc_next[WIDTH-1:0];
                     r_carry  <= (w_acc_next[2*WIDTH-1:WIDTH] != '0);
                     r_zero   <= (w_acc_next[WIDTH-1:0] == '0);
                  end else begin
                     r_result <= w_sh_next;
                     r_carry  <= w_sh_out;
                     r_zero   <= (w_sh_next == '0);
                  end
               end
            end
            default: begin
               if (i_resp_ready) begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign o_req_ready  = (r_state == S_IDLE) && !i_reset;
   assign o_resp_valid = (r_state == S_DONE) && !i_reset;
   assign o_busy       = (r_state != S_IDLE) && !i_reset;
   assign o_result     = i_reset ? '0 : r_result;
   assign o_carry      = r_carry    && !i_reset;
   assign o_overflow   = r_overflow && !i_reset;
   assign o_zero       = r_zero     && !i_reset;
   assign o_error      = r_error    && !i_reset;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Request/response controller that owns the 16-bit ALU datapath and sequences it for the CPU. It accepts one operation at a time over a valid/ready handshake, runs single-cycle ops (add, sub, logic, compare) in one pass, and runs iterative ops (shift-add multiply, multi-bit shifts) over several cycles. It then holds a registered result plus flags until the consumer takes it. It sits between instruction decode and register writeback.

## Interface
- WIDTH, 16, datapath width; fixed at 16, other values unsupported.
- Clock  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high.
- ReqValid  in  1  request present.
- ReqReady  out  1  controller can accept; high only in IDLE and only while Reset is low.
- Opcode  in  5  operation select, sampled on accept.
- OperandA  in  16  first operand, sampled on accept.
- OperandB  in  16  second operand or shift amount (bits 3:0), sampled on accept.
- RespValid  out  1  response present.
- RespReady  in  1  consumer takes response.
- Result  out  16  registered result.
- Carry  out  1  carry/borrow/shifted-out bit.
- Overflow  out  1  signed overflow.
- Zero  out  1  Result == 0.
- Error  out  1  illegal opcode.
- Busy  out  1  state != IDLE.

## Operation
- Opcodes:
  - 0 ADD: A+B; Carry = carry out; Overflow = signed overflow.
  - 1 SUB: A-B; Carry = borrow, 1 when A<B unsigned; Overflow = signed overflow.
  - 2 AND, 3 OR, 4 XOR.
  - 5 NOT: result is ~A.
  - 6 EQ: Result = 0x0001 if A==B, else 0x0000.
  - 7 MUL: low 16 bits of unsigned A*B; Carry = 1 when the high 16 bits are nonzero.
  - 8 SHL: logical shift left by B[3:0].
  - 9 SHR: logical shift right by B[3:0]. For both shifts, Carry = last bit shifted out.
  - 10-31 illegal: Result = 0, Error = 1, Zero = 1.
- Carry and Overflow are 0 wherever the list above does not define them. Error is 0 for legal ops.
- States:
  - IDLE: ReqValid && ReqReady -> latch operands, go to EXEC (single-cycle op, illegal op, or shift by 0) or ITER.
  - EXEC: compute; register Result and flags -> DONE.
  - ITER: MUL loads a 4-bit counter with 15 and examines one B bit per cycle, LSB first, accumulating shifted A in a 32-bit accumulator. Shifts load the counter with k-1 and move one bit per cycle. Counter reaching 0 -> register outputs -> DONE.
  - DONE: RespValid = 1; RespReady -> IDLE.
- Request inputs are ignored outside IDLE. Response outputs are stable while RespValid is high.
- RespReady is ignored outside DONE.

## Timing
- Reset (any state, including mid-ITER): next edge goes to IDLE. The iteration in flight is discarded and no response is produced. Result = 0, Carry/Overflow/Zero/Error = 0, RespValid = 0, Busy = 0, ReqReady = 0 while Reset is high.
- Latency is counted from the accept edge to the edge after which RespValid = 1:
  - single-cycle ops, illegal ops, shift by 0: 1 edge.
  - MUL: 16 edges.
  - shift by k (1..15): k edges.
- DONE with RespReady high takes 1 edge to IDLE. ReqReady rises the cycle after the response handshake, so there is no request accept in the same cycle as a response handshake. Minimum single-op spacing is 3 cycles.
- RespReady held low keeps DONE indefinitely: outputs frozen, ReqReady = 0.
- Wrap-around: ADD/SUB/MUL results are modulo 2^16; overflow is reported only through flags.

## Test plan
- ADD 0x7FFF+0x0001 -> Result 0x8000, Carry 0, Overflow 1, Zero 0, RespValid 1 edge after accept. SUB 0x0003-0x0005 -> 0xFFFE, Carry 1, Overflow 0.
- MUL 0x00FF*0x0003 -> 0x02FD, Carry 0, RespValid exactly 16 edges after accept, Busy high throughout. MUL 0x0100*0x0100 -> 0x0000, Carry 1, Zero 1.
- SHR 0x0013 by 2 -> 0x0004, Carry 1, latency 2. SHL 0x8001 by 0 -> 0x8001, Carry 0, latency 1.
- Backpressure: RespReady low 5 cycles after an AND 0xF0F0&0x0FF0 response (0x00F0) -> outputs stable, ReqReady 0, a ReqValid pulse with ADD is not accepted. RespReady high -> IDLE next edge, then ADD is accepted.
- Reset asserted at the 8th MUL iteration edge -> IDLE next edge, RespValid never rises, outputs 0. Then EQ 0x1234,0x1234 -> 0x0001, Zero 0.
- Opcode 0x1F, A = 0xFFFF -> Result 0x0000, Error 1, Zero 1, latency 1. A following legal XOR 0xAAAA^0xFFFF -> 0x5555, Error 0.
